// File: rtl/histogram_scan_ctrl_pkg.sv
// Shared definitions for the histogram scan controller.
//   scanState_t      : controller states (idle, drain, scan, flush, done).
//   DEF_DATA_SIZE    : default sample / bin index width.
//   DEF_LENGTH_SIZE  : default bin count width.
//   SUM_W            : total width at defaults (count width + index width,
//                      enough to sum every bin at full count).
//   MIN_DRAIN        : shortest drain that still covers the 5-cycle
//                      subtract write path of the chain.
package histogram_scan_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_SCAN,
      ST_FLUSH,
      ST_DONE
   } scanState_t;

   localparam int DEF_DATA_SIZE   = 4;
   localparam int DEF_LENGTH_SIZE = 6;
   localparam int SUM_W           = DEF_LENGTH_SIZE + DEF_DATA_SIZE;
   localparam int MIN_DRAIN       = 6;

endpackage

// File: rtl/histogram_scan_ctrl_peak_acc.sv
// histogram_peak_acc: running total / peak tracker for one readout scan.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears everything).
//   clear      : zero the running values (issued on entry to the scan).
//   accEn      : a bin count is present this cycle (one stage ahead of
//                bin_valid, so the last bin lands before the done cycle).
//   accIdx     : bin index of that count.
//   accCount   : the count itself.
//   latch      : copy the running values, including this cycle's bin, into
//                the held summary outputs.
//   peakBin, peakCount, total : held summary, changes only on latch.
module histogram_peak_acc
   import histogram_scan_ctrl_pkg::*;
#(
   parameter int DATA_SIZE   = DEF_DATA_SIZE,
   parameter int LENGTH_SIZE = DEF_LENGTH_SIZE,
   parameter int SUM_BITS    = SUM_W
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   accEn,
   input  logic [DATA_SIZE-1:0]   accIdx,
   input  logic [LENGTH_SIZE-1:0] accCount,
   input  logic                   latch,
   output logic [DATA_SIZE-1:0]   peakBin,
   output logic [LENGTH_SIZE-1:0] peakCount,
   output logic [SUM_BITS-1:0]    total
);

   logic [SUM_BITS-1:0]    runTotal,   nextTotal;
   logic [LENGTH_SIZE-1:0] runPeak,    nextPeak;
   logic [DATA_SIZE-1:0]   runPeakBin, nextPeakBin;

   // Strict greater-than: on a tie the earlier (lower) index is kept.
   always_comb begin
      nextTotal   = runTotal;
      nextPeak    = runPeak;
      nextPeakBin = runPeakBin;
      if (accEn) begin
         nextTotal = runTotal + SUM_BITS'(accCount);
         if (accCount > runPeak) begin
            nextPeak    = accCount;
            nextPeakBin = accIdx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         runTotal   <= '0;
         runPeak    <= '0;
         runPeakBin <= '0;
         total      <= '0;
         peakCount  <= '0;
         peakBin    <= '0;
      end else begin
         if (clear) begin
            runTotal   <= '0;
            runPeak    <= '0;
            runPeakBin <= '0;
         end else begin
            runTotal   <= nextTotal;
            runPeak    <= nextPeak;
            runPeakBin <= nextPeakBin;
         end
         if (latch) begin
            total     <= nextTotal;
            peakCount <= nextPeak;
            peakBin   <= nextPeakBin;
         end
      end
   end

endmodule

// File: rtl/histogram_scan_ctrl.sv
// histogram_scan_ctrl: sits in front of the histogram chain (window FIFO +
// bin-count memory). Forwards the sample stream and, on request, stops the
// stream, lets in-flight read-modify-writes retire, then reads every bin
// through the single read port and reports counts plus peak/total.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset.
//   start                 : one-cycle scan request, ignored while busy.
//   s_valid/s_data/s_ready: upstream sample handshake.
//   h_valid/h_data        : sample into the chain (s_valid & s_ready, s_data).
//   his_rd/his_rd_add     : chain read strobe and bin address.
//   his_rd_data           : chain read data, RD_LAT cycles after his_rd.
//   bin_valid/idx/count   : one pulse per bin during the scan.
//   busy                  : scan in progress.
//   done                  : one-cycle pulse, summary valid from this cycle.
//   peak_bin/peak_count/total : summary, held until the next done.
module histogram_scan_ctrl
   import histogram_scan_ctrl_pkg::*;
#(
   parameter int DATA_SIZE   = DEF_DATA_SIZE,
   parameter int DATA_NUM    = 16,
   parameter int LENGTH_SIZE = DEF_LENGTH_SIZE,
   parameter int DRAIN       = 6,
   parameter int RD_LAT      = 2
)(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             s_valid,
   input  logic [DATA_SIZE-1:0]             s_data,
   output logic                             s_ready,
   output logic                             h_valid,
   output logic [DATA_SIZE-1:0]             h_data,
   output logic                             his_rd,
   output logic [DATA_SIZE-1:0]             his_rd_add,
   input  logic [LENGTH_SIZE-1:0]           his_rd_data,
   output logic                             bin_valid,
   output logic [DATA_SIZE-1:0]             bin_idx,
   output logic [LENGTH_SIZE-1:0]           bin_count,
   output logic                             busy,
   output logic                             done,
   output logic [DATA_SIZE-1:0]             peak_bin,
   output logic [LENGTH_SIZE-1:0]           peak_count,
   output logic [LENGTH_SIZE+DATA_SIZE-1:0] total
);

   // A drain shorter than the subtract write path would let the scan read a
   // bin before its last update lands, so it is never allowed below minimum.
   localparam int DRAIN_EFF = (DRAIN < MIN_DRAIN) ? MIN_DRAIN : DRAIN;
   localparam int CNT_MAX   = (DRAIN_EFF > RD_LAT) ? DRAIN_EFF : RD_LAT;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam logic [DATA_SIZE-1:0] LAST_ADD = DATA_SIZE'(DATA_NUM - 1);

   scanState_t           state;
   logic [CNT_W-1:0]     waitCnt;
   logic [DATA_SIZE-1:0] rdAdd;
   logic                 rdOn;
   logic                 readyReg;
   logic                 doneReg;

   logic [RD_LAT-1:0]    rdFlagPipe;
   logic [DATA_SIZE-1:0] rdAddPipe [RD_LAT];

   logic                   binValidReg;
   logic [DATA_SIZE-1:0]   binIdxReg;
   logic [LENGTH_SIZE-1:0] binCountReg;

   logic accClear;
   logic accLatch;

   assign s_ready    = readyReg;
   assign h_valid    = s_valid & readyReg;
   assign h_data     = s_data;
   assign his_rd     = rdOn;
   assign his_rd_add = rdAdd;
   assign busy       = (state != ST_IDLE);
   assign done       = doneReg;
   assign bin_valid  = binValidReg;
   assign bin_idx    = binIdxReg;
   assign bin_count  = binCountReg;

   // Running values clear as the scan starts; the summary latches on the
   // cycle that enters DONE so it is already valid while done is high.
   assign accClear = (state == ST_DRAIN) && (waitCnt == '0);
   assign accLatch = (state == ST_FLUSH) && (waitCnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         waitCnt  <= '0;
         rdAdd    <= '0;
         rdOn     <= 1'b0;
         readyReg <= 1'b0;
         doneReg  <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (state)
            ST_IDLE: begin
               readyReg <= 1'b1;
               if (start) begin
                  state    <= ST_DRAIN;
                  waitCnt  <= CNT_W'(DRAIN_EFF - 1);
                  readyReg <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (waitCnt == '0) begin
                  state <= ST_SCAN;
                  rdAdd <= '0;
                  rdOn  <= 1'b1;
               end else begin
                  waitCnt <= waitCnt - 1'b1;
               end
            end
            ST_SCAN: begin
               rdAdd <= rdAdd + 1'b1;
               if (rdAdd == LAST_ADD) begin
                  state   <= ST_FLUSH;
                  rdOn    <= 1'b0;
                  waitCnt <= CNT_W'(RD_LAT - 1);
               end
            end
            ST_FLUSH: begin
               if (waitCnt == '0) begin
                  state   <= ST_DONE;
                  doneReg <= 1'b1;
               end else begin
                  waitCnt <= waitCnt - 1'b1;
               end
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               readyReg <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Read-latency alignment: flag and address travel RD_LAT stages so they
   // meet his_rd_data from the same read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdFlagPipe <= '0;
      end else begin
         rdFlagPipe[0] <= rdOn;
         for (int i = 1; i < RD_LAT; i++) begin
            rdFlagPipe[i] <= rdFlagPipe[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      rdAddPipe[0] <= rdAdd;
      for (int i = 1; i < RD_LAT; i++) begin
         rdAddPipe[i] <= rdAddPipe[i-1];
      end
   end

   // Readout output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         binValidReg <= 1'b0;
         binIdxReg   <= '0;
         binCountReg <= '0;
      end else begin
         binValidReg <= rdFlagPipe[RD_LAT-1];
         if (rdFlagPipe[RD_LAT-1]) begin
            binIdxReg   <= rdAddPipe[RD_LAT-1];
            binCountReg <= his_rd_data;
         end
      end
   end

   histogram_peak_acc #(
      .DATA_SIZE   (DATA_SIZE),
      .LENGTH_SIZE (LENGTH_SIZE),
      .SUM_BITS    (LENGTH_SIZE + DATA_SIZE)
   ) uPeakAcc (
      .clk       (clk),
      .rst       (rst),
      .clear     (accClear),
      .accEn     (rdFlagPipe[RD_LAT-1]),
      .accIdx    (rdAddPipe[RD_LAT-1]),
      .accCount  (his_rd_data),
      .latch     (accLatch),
      .peakBin   (peak_bin),
      .peakCount (peak_count),
      .total     (total)
   );

endmodule

// File: tb/tb_histogram_scan_ctrl.sv
// Bench for histogram_scan_ctrl at default parameters. Contains a small
// stand-in for the histogram chain (sliding window of winLen samples plus a
// bin-count memory read with 2 cycles of latency).
module tb_histogram_scan_ctrl;

   localparam int TR = 48;

   logic       clk;
   logic       rst;
   logic       start;
   logic       s_valid;
   logic [3:0] s_data;
   logic       s_ready;
   logic       h_valid;
   logic [3:0] h_data;
   logic       his_rd;
   logic [3:0] his_rd_add;
   logic [5:0] his_rd_data;
   logic       bin_valid;
   logic [3:0] bin_idx;
   logic [5:0] bin_count;
   logic       busy;
   logic       done;
   logic [3:0] peak_bin;
   logic [5:0] peak_count;
   logic [9:0] total;

   histogram_scan_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .h_valid     (h_valid),
      .h_data      (h_data),
      .his_rd      (his_rd),
      .his_rd_add  (his_rd_add),
      .his_rd_data (his_rd_data),
      .bin_valid   (bin_valid),
      .bin_idx     (bin_idx),
      .bin_count   (bin_count),
      .busy        (busy),
      .done        (done),
      .peak_bin    (peak_bin),
      .peak_count  (peak_count),
      .total       (total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- chain stand-in ----------------
   logic [5:0] hisMem [16];
   logic [3:0] winQ [$];
   int         winLen;
   bit         modelClr;
   logic [5:0] rdStage;

   always @(posedge clk) begin
      if (modelClr) begin
         for (int i = 0; i < 16; i++) hisMem[i] <= 6'd0;
         winQ.delete();
      end else if (h_valid) begin
         if (winQ.size() >= winLen) begin
            if (winQ[0] != h_data) begin
               hisMem[h_data]  <= hisMem[h_data] + 6'd1;
               hisMem[winQ[0]] <= hisMem[winQ[0]] - 6'd1;
            end
            void'(winQ.pop_front());
         end else begin
            hisMem[h_data] <= hisMem[h_data] + 6'd1;
         end
         winQ.push_back(h_data);
      end
      // Garbage when no read is issued, so a misaligned capture shows up.
      rdStage     <= his_rd ? hisMem[his_rd_add] : 6'h3F;
      his_rd_data <= rdStage;
   end

   // ---------------- arbitration monitor ----------------
   int monCyc     = 0;
   int lastHvCyc  = -100;
   int arbViol    = 0;

   always @(negedge clk) begin
      #2;
      monCyc <= monCyc + 1;
      if (h_valid) lastHvCyc <= monCyc;
      if (his_rd && (h_valid || (monCyc - lastHvCyc <= 6))) arbViol <= arbViol + 1;
   end

   // ---------------- checking ----------------
   int nChecks = 0;
   int nPass   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      nChecks++;
      if (act == exp) nPass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // per-cycle trace of one scan, cycle 0 = the start cycle
   bit       trHv[TR], trRd[TR], trBv[TR], trDone[TR], trReady[TR], trBusy[TR];
   logic [3:0] trIdx[TR], trPb[TR];
   logic [5:0] trCnt[TR], trPc[TR];
   logic [9:0] trTot[TR];

   int bvCount, doneCount, doneAt, firstRd, lastHv, orderBad, firstBv, lastBv;
   int binGot[16];

   // Entered right at a negedge.
   task automatic runScan(input int nCyc, input bit keepValid, input int again1, input int again2);
      for (int k = 0; k < nCyc; k++) begin
         start   = (k == 0) || (k == again1) || (k == again2);
         s_valid = keepValid;
         s_data  = 4'h2;
         #1;
         trHv[k]    = h_valid;
         trRd[k]    = his_rd;
         trBv[k]    = bin_valid;
         trIdx[k]   = bin_idx;
         trCnt[k]   = bin_count;
         trDone[k]  = done;
         trReady[k] = s_ready;
         trBusy[k]  = busy;
         trPb[k]    = peak_bin;
         trPc[k]    = peak_count;
         trTot[k]   = total;
         @(negedge clk);
      end
      start   = 1'b0;
      s_valid = 1'b0;
   endtask

   task automatic summarize(input int nCyc);
      bvCount = 0; doneCount = 0; doneAt = -1; firstRd = -1; lastHv = -1;
      orderBad = 0; firstBv = -1; lastBv = -1;
      for (int i = 0; i < 16; i++) binGot[i] = -1;
      for (int k = 0; k < nCyc; k++) begin
         if (trRd[k] && firstRd < 0) firstRd = k;
         if (trHv[k] && firstRd < 0) lastHv = k;
         if (trDone[k]) begin
            doneCount++;
            if (doneAt < 0) doneAt = k;
         end
         if (trBv[k]) begin
            if (trIdx[k] != 4'(bvCount)) orderBad++;
            binGot[trIdx[k]] = int'(trCnt[k]);
            if (firstBv < 0) firstBv = k;
            lastBv = k;
            bvCount++;
         end
      end
      if (doneAt < 0) doneAt = 0;
   endtask

   task automatic feed(input logic [3:0] val, input int n);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = val;
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic clearChain(input int len);
      modelClr = 1'b1;
      winLen   = len;
      @(negedge clk);
      modelClr = 1'b0;
   endtask

   typedef struct {
      int winLen;
      logic [3:0] vA; int nA;
      logic [3:0] vB; int nB;
      logic [3:0] vC; int nC;
      logic [3:0] eBinA; int eCntA;
      logic [3:0] eBinB; int eCntB;
      logic [3:0] eBinC; int eCntC;
      int ePeakBin; int ePeakCnt; int eTotal;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int exp;
      bit found;
      int seenDone;

      //            win  A        B        C        expA      expB      expC      peak  pcnt tot
      vecs[0] = '{32, 4'd3, 16, 4'd9, 4, 4'd0, 0, 4'd3, 16, 4'd9, 4, 4'd0, 0, 3, 16, 20};
      vecs[1] = '{32, 4'd12, 7, 4'd5, 7, 4'd0, 3, 4'd12, 7, 4'd5, 7, 4'd0, 3, 5, 7, 17};
      vecs[2] = '{16, 4'd1, 16, 4'd6, 5, 4'd0, 0, 4'd1, 11, 4'd6, 5, 4'd0, 0, 1, 11, 16};
      vecs[3] = '{32, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0};
      vecs[4] = '{32, 4'd15, 2, 4'd0, 2, 4'd0, 0, 4'd15, 2, 4'd0, 2, 4'd0, 0, 0, 2, 4};
      vecs[5] = '{64, 4'd7, 63, 4'd0, 0, 4'd0, 0, 4'd7, 63, 4'd0, 0, 4'd0, 0, 7, 63, 63};
      vecs[6] = '{16, 4'd4, 20, 4'd0, 0, 4'd0, 0, 4'd4, 16, 4'd0, 0, 4'd0, 0, 4, 16, 16};

      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 4'h0;
      modelClr = 1'b1; winLen = 32;
      repeat (3) @(negedge clk);
      #1;
      check("reset s_ready", s_ready, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset his_rd", his_rd, 0);
      check("reset bin_valid", bin_valid, 0);
      check("reset total", total, 0);
      @(negedge clk);
      rst = 1'b0; modelClr = 1'b0;
      @(negedge clk);
      #1;
      check("s_ready after reset", s_ready, 1);
      @(negedge clk);

      // ---------------- table-driven scans ----------------
      for (int v = 0; v < 7; v++) begin
         clearChain(vecs[v].winLen);
         feed(vecs[v].vA, vecs[v].nA);
         feed(vecs[v].vB, vecs[v].nB);
         feed(vecs[v].vC, vecs[v].nC);
         @(negedge clk);
         runScan(40, 1'b0, -1, -1);
         summarize(40);
         check($sformatf("v%0d bin_valid count", v), bvCount, 16);
         check($sformatf("v%0d bin order", v), orderBad, 0);
         check($sformatf("v%0d bin contiguous", v), lastBv - firstBv + 1, 16);
         for (int i = 0; i < 16; i++) begin
            exp = 0;
            if (vecs[v].eCntA != 0 && i == int'(vecs[v].eBinA)) exp += vecs[v].eCntA;
            if (vecs[v].eCntB != 0 && i == int'(vecs[v].eBinB)) exp += vecs[v].eCntB;
            if (vecs[v].eCntC != 0 && i == int'(vecs[v].eBinC)) exp += vecs[v].eCntC;
            check($sformatf("v%0d bin %0d count", v, i), binGot[i], exp);
         end
         check($sformatf("v%0d done pulses", v), doneCount, 1);
         check($sformatf("v%0d peak_bin", v), trPb[doneAt], vecs[v].ePeakBin);
         check($sformatf("v%0d peak_count", v), trPc[doneAt], vecs[v].ePeakCnt);
         check($sformatf("v%0d total", v), trTot[doneAt], vecs[v].eTotal);
         check($sformatf("v%0d total held", v), trTot[39], vecs[v].eTotal);
         check($sformatf("v%0d peak held", v), trPc[39], vecs[v].ePeakCnt);
      end

      // ---------------- latency with s_valid held high ----------------
      clearChain(32);
      runScan(40, 1'b1, -1, -1);
      summarize(40);
      check("lat s_ready at start", trReady[0], 1);
      check("lat s_ready after start", trReady[1], 0);
      check("lat h_valid in start cycle", trHv[0], 1);
      check("lat h_valid after start", trHv[1], 0);
      check("lat last h_valid cycle", lastHv, 0);
      check("lat idle gap before first his_rd", firstRd - lastHv - 1, 6);
      // start cycle counted as the first of 26: done lands in cycle 25
      check("lat start to done", doneAt, 25);
      check("lat s_ready during done", trReady[25], 0);
      check("lat s_ready after done", trReady[26], 1);
      check("lat busy after done", trBusy[26], 0);
      check("lat stream resumes", trHv[26], 1);
      @(negedge clk);

      // ---------------- start pulses during an active scan ----------------
      clearChain(32);
      feed(4'd8, 3);
      @(negedge clk);
      runScan(45, 1'b0, 3, 10);
      summarize(45);
      check("restart done pulses", doneCount, 1);
      check("restart done cycle", doneAt, 25);
      check("restart bin_valid count", bvCount, 16);
      check("restart idle afterwards", trBusy[30], 0);
      check("restart total", trTot[doneAt], 3);

      // ---------------- reset in the middle of the scan ----------------
      start = 1'b1;
      s_data = 4'h0;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         #1;
         if (his_rd && his_rd_add == 4'd8) found = 1'b1;
         else @(negedge clk);
      end
      check("rst reached address 8", found, 1);
      rst = 1'b1;
      #1;
      check("rst s_ready", s_ready, 0);
      check("rst h_valid", h_valid, 0);
      check("rst busy", busy, 0);
      check("rst his_rd", his_rd, 0);
      check("rst his_rd_add", his_rd_add, 0);
      check("rst bin_valid", bin_valid, 0);
      check("rst bin_idx", bin_idx, 0);
      check("rst bin_count", bin_count, 0);
      check("rst done", done, 0);
      check("rst peak_bin", peak_bin, 0);
      check("rst peak_count", peak_count, 0);
      check("rst total", total, 0);
      seenDone = 0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (done) seenDone++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (done) seenDone++;
         if (k == 1) begin
            check("post-rst s_ready", s_ready, 1);
            check("post-rst busy", busy, 0);
         end
         @(negedge clk);
      end
      check("rst no done", seenDone, 0);

      clearChain(32);
      feed(4'd2, 8);
      @(negedge clk);
      runScan(40, 1'b0, -1, -1);
      summarize(40);
      check("post-rst done pulses", doneCount, 1);
      check("post-rst bin_valid count", bvCount, 16);
      check("post-rst bin 2", binGot[2], 8);
      check("post-rst peak_bin", trPb[doneAt], 2);
      check("post-rst peak_count", trPc[doneAt], 8);
      check("post-rst total", trTot[doneAt], 8);

      repeat (2) @(negedge clk);
      check("arbitration violations", arbViol, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/histogram_scan_ctrl.md
Name: histogram_scan_ctrl

Overview:
- Scheduler in front of the histogram-chain datapath: the sliding-window frame FIFO plus the bin-count memory.
- Passes the sample stream into the chain and arbitrates the single histogram read port between stream updates and a host-requested readout scan.
- On `start`: holds off the stream, waits for in-flight add/subtract read-modify-writes to retire, reads every bin back-to-back and emits each count.
- Also reports peak bin, peak count and total, so the host never drives `HisMemRD` directly.

Parameters:
- DATA_SIZE, 4, sample width; bin index width.
- DATA_NUM, 16, number of bins (2**DATA_SIZE).
- LENGTH_SIZE, 6, bin count width.
- DRAIN, 6, idle cycles after the last forwarded sample before the first scan read. Must be ≥ 6, to cover the 5-cycle subtract write path.
- RD_LAT, 2, cycles from `his_rd` to valid `his_rd_data`.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle scan request; ignored while busy=1.
- s_valid  in  1  upstream sample valid.
- s_data  in  DATA_SIZE  upstream sample.
- s_ready  out  1  upstream may transfer; transfer occurs when s_valid&s_ready.
- h_valid  out  1  to chain Valid; equals s_valid&s_ready (combinational).
- h_data  out  DATA_SIZE  to chain Data; equals s_data.
- his_rd  out  1  to chain HisMemRD.
- his_rd_add  out  DATA_SIZE  to chain HisMemRDAdd.
- his_rd_data  in  LENGTH_SIZE  from chain HisMemRDData.
- bin_valid  out  1  one pulse per bin during the scan.
- bin_idx  out  DATA_SIZE  bin index for bin_valid.
- bin_count  out  LENGTH_SIZE  count for bin_valid.
- busy  out  1  scan in progress (any state other than IDLE).
- done  out  1  one-cycle pulse; the summary outputs are valid from this cycle.
- peak_bin  out  DATA_SIZE  index of the highest count, held until the next done.
- peak_count  out  LENGTH_SIZE  highest count, held.
- total  out  LENGTH_SIZE+DATA_SIZE  sum of all counts, held.

Behaviour:
- Reset values (while rst is high):
  - s_ready=0.
  - All other outputs 0.
  - State is IDLE.
- Reset asserted mid-scan aborts the scan immediately: no done pulse, summary outputs cleared.
- State machine:
  - IDLE: s_ready=1. On start, go to DRAIN; s_ready=0 from the next cycle on. A sample accepted in the same cycle as start is forwarded normally.
  - DRAIN: s_ready=0. A counter loads DRAIN-1 on entry and decrements; at 0 go to SCAN with address counter = 0.
  - SCAN: his_rd=1 and his_rd_add=address every cycle. Address increments. After issuing address DATA_NUM-1, go to FLUSH. This takes exactly DATA_NUM cycles.
  - FLUSH: his_rd=0. Wait RD_LAT cycles so the last read returns, then go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE; s_ready=1 again from the following cycle.
- Readout pipeline:
  - his_rd and his_rd_add are delayed RD_LAT stages through a shift register.
  - When the delayed read flag is set: bin_valid=1, bin_idx=delayed address, bin_count=his_rd_data, all registered.
  - bin_valid pulses exactly DATA_NUM times, for indices 0..DATA_NUM-1 in order and contiguous.
- Accumulation:
  - The running total and peak registers clear on entry to SCAN.
  - total accumulates zero-extended counts; its width guarantees no overflow.
  - Peak updates only on a strict greater-than, so ties keep the lowest index. All-zero counts give peak_bin=0 and peak_count=0.
  - Summary outputs latch at done and are held until the next done.
- Arbitration rule: h_valid and his_rd are never high in the same cycle, and his_rd is never high within DRAIN cycles of the last h_valid. This is an assertion target.
- start during busy: ignored, not queued.
- Scan latency: start to done = 1 + DRAIN + DATA_NUM + RD_LAT + 1 cycles, which is 26 at defaults.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, DRAIN, SCAN, FLUSH, DONE);
  - the localparam SUM_W = LENGTH_SIZE+DATA_SIZE;
  - the minimum-DRAIN constant 6.
- One natural sub-module: histogram_peak_acc, which handles clear/accumulate of total, peak_count and peak_bin, driven by bin_valid.
- The FSM and read-latency shift register stay in the top module.

Test Plan:
- Feed 16 samples of value 3 and 4 of value 9 with the window not yet full, then start. Required: bin_valid ×16; bin 3=16, bin 9=4, others 0; peak_bin=3, peak_count=16, total=20.
- Assert start with s_valid continuously high. Required: s_ready falls the cycle after start; first his_rd exactly 6 cycles after the last h_valid; done 26 cycles after start; s_ready returns the cycle after done.
- Bins 5 and 12 both hold count 7 and all others hold less. Required: peak_bin=5, peak_count=7.
- Pulse start again at cycles 3 and 10 of an active scan. Required: no effect; one done only; bin_valid count = 16.
- Assert rst during SCAN at address 8. Required: all outputs 0 at once; no done; after release, IDLE with s_ready=1; a new start completes normally.
- After the window fills (16 samples), feed 5 more samples and then scan. Required: total=16; the counts reflect only the last 16 samples.
